// File: rtl/marquee_scheduler.sv
// Scroll-position sequencer for the six-digit marquee: owns the head index,
// paces it with a prescaler and produces six registered, wrap-correct symbol codes.
module marquee_scheduler #(
  parameter int MSG_LEN    = 10,
  parameter int DIV        = 25_000_000,
  parameter int HOLD_STEPS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] head,
  output logic [3:0] ch0,
  output logic [3:0] ch1,
  output logic [3:0] ch2,
  output logic [3:0] ch3,
  output logic [3:0] ch4,
  output logic [3:0] ch5,
  output logic       adv,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV);
  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_STEPS);
  localparam logic [3:0]    HEAD_MAX  = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    head_q, head_adv, head_d;
  logic [3:0]    ch_q [6];
  logic [3:0]    ch_d [6];
  logic          adv_q, do_adv;

  // head+n never reaches 2*MSG_LEN, so one conditional subtract is enough.
  function automatic logic [3:0] sym(input logic [3:0] h, input int n);
    logic [4:0] s;
    s = {1'b0, h} + 5'(n);
    return (s >= 5'(MSG_LEN)) ? (s[3:0] - 4'(MSG_LEN)) : s[3:0];
  endfunction

  always_comb begin
    if (dir) head_adv = (head_q == 4'd0) ? HEAD_MAX : head_q - 4'd1;
    else     head_adv = (head_q == HEAD_MAX) ? 4'd0 : head_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    do_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        hold_d  = '0;
        if (run)       state_d = S_RUN;
        else if (step) do_adv  = 1'b1;
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
          presc_d = '0;
          hold_d  = '0;
        end else if (presc_q == PRE_TC) begin
          presc_d = '0;
          do_adv  = 1'b1;
          if (HOLD_STEPS > 0 && head_adv == 4'd0) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_HOLD: begin
        // Dwell counts whole scroll periods; the last one returns to RUN without advancing.
        if (!run) begin
          state_d = S_IDLE;
          presc_d = '0;
          hold_d  = '0;
        end else if (presc_q == PRE_TC) begin
          presc_d = '0;
          if (hold_q == HW'(1)) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    head_d = do_adv ? head_adv : head_q;
    for (int n = 0; n < 6; n++) ch_d[n] = sym(head_d, n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      head_q  <= 4'd0;
      adv_q   <= 1'b0;
      for (int n = 0; n < 6; n++) ch_q[n] <= 4'(n);
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      head_q  <= head_d;
      adv_q   <= do_adv;
      for (int n = 0; n < 6; n++) ch_q[n] <= ch_d[n];
    end
  end

  assign head  = head_q;
  assign ch0   = ch_q[0];
  assign ch1   = ch_q[1];
  assign ch2   = ch_q[2];
  assign ch3   = ch_q[3];
  assign ch4   = ch_q[4];
  assign ch5   = ch_q[5];
  assign adv   = adv_q;
  assign state = state_q;

endmodule

// File: tb/tb_marquee_scheduler.sv
// Directed, table-driven bench for marquee_scheduler (MSG_LEN=10, DIV=4, HOLD_STEPS=2).
module tb_marquee_scheduler;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  logic       clk, rst, run, dir, step;
  logic [3:0] head, ch0, ch1, ch2, ch3, ch4, ch5;
  logic       adv;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       run;
    logic       dir;
    logic       step;
    logic [3:0] head;
    logic [1:0] st;
    logic       adv;
  } vec_t;

  vec_t vecs[$];

  marquee_scheduler #(.MSG_LEN(10), .DIV(4), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .step(step),
    .head(head), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4), .ch5(ch5),
    .adv(adv), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_ch(input int h);
    logic [23:0] r;
    for (int n = 0; n < 6; n++) r[23-4*n -: 4] = 4'((h + n) % 10);
    return r;
  endfunction

  task automatic check_all(input string nm, input int idx, input int h,
                           input logic [1:0] st, input logic a);
    chk({nm, ".head"}, idx, int'(head), h);
    chk({nm, ".state"}, idx, int'(state), int'(st));
    chk({nm, ".adv"}, idx, int'(adv), int'(a));
    chk({nm, ".ch"}, idx, int'({ch0, ch1, ch2, ch3, ch4, ch5}), int'(exp_ch(h)));
  endtask

  task automatic add(input logic r, input logic d, input logic s, input int h,
                     input logic [1:0] st, input logic a);
    vec_t v;
    v.run = r; v.dir = d; v.step = s; v.head = 4'(h); v.st = st; v.adv = a;
    vecs.push_back(v);
  endtask

  // Three quiet cycles then one advance edge: one scroll period at DIV=4.
  task automatic add_period(input logic r, input logic d, input logic s,
                            input int from_h, input int to_h,
                            input logic [1:0] st_to);
    for (int i = 0; i < 3; i++) add(r, d, s, from_h, ST_RUN, 1'b0);
    add(r, d, s, to_h, st_to, 1'b1);
  endtask

  task automatic add_hold(input logic d, input int after_h);
    for (int i = 0; i < 7; i++) add(1'b1, d, 1'b0, 0, ST_HOLD, 1'b0);
    add(1'b1, d, 1'b0, 0, ST_RUN, 1'b0);
    add_period(1'b1, d, 1'b0, 0, after_h, ST_RUN);
  endtask

  initial begin
    // Manual stepping, 3 cycles apart.
    for (int i = 1; i <= 10; i++) begin
      add(1'b0, 1'b0, 1'b1, i % 10, ST_IDLE, 1'b1);
      add(1'b0, 1'b0, 1'b0, i % 10, ST_IDLE, 1'b0);
      add(1'b0, 1'b0, 1'b0, i % 10, ST_IDLE, 1'b0);
    end
    // Auto-scroll from 0; step on the entry cycle is ignored.
    add(1'b1, 1'b0, 1'b1, 0, ST_RUN, 1'b0);
    for (int i = 1; i <= 9; i++) add_period(1'b1, 1'b0, 1'b0, i - 1, i, ST_RUN);
    add_period(1'b1, 1'b0, 1'b0, 9, 0, ST_HOLD);
    add_hold(1'b0, 1);
    // Run drop on the terminal-count cycle, then re-entry.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1, ST_RUN, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1, ST_IDLE, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1, ST_IDLE, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1, ST_RUN, 1'b0);
    add_period(1'b1, 1'b0, 1'b0, 1, 2, ST_RUN);
    // Step held high throughout RUN has no effect.
    for (int h = 3; h <= 5; h++) add_period(1'b1, 1'b0, 1'b1, h - 1, h, ST_RUN);
    // Direction flip, then backward through the wrap to 9.
    add_period(1'b1, 1'b1, 1'b0, 5, 4, ST_RUN);
    for (int h = 3; h >= 1; h--) add_period(1'b1, 1'b1, 1'b0, h + 1, h, ST_RUN);
    add_period(1'b1, 1'b1, 1'b0, 1, 0, ST_HOLD);
    add_hold(1'b1, 9);
    // Back to IDLE, manual backward step, then run until head=7.
    add(1'b0, 1'b1, 1'b0, 9, ST_IDLE, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8, ST_IDLE, 1'b1);
    add(1'b0, 1'b1, 1'b0, 8, ST_IDLE, 1'b0);
    add(1'b1, 1'b1, 1'b0, 8, ST_RUN, 1'b0);
    add_period(1'b1, 1'b1, 1'b0, 8, 7, ST_RUN);

    rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0;
    #2;
    check_all("reset_async", 0, 0, ST_IDLE, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset_release", 0, 0, ST_IDLE, 1'b0);

    foreach (vecs[i]) begin
      run = vecs[i].run; dir = vecs[i].dir; step = vecs[i].step;
      @(posedge clk); #1;
      check_all("vec", i, int'(vecs[i].head), vecs[i].st, vecs[i].adv);
    end

    // Asynchronous reset mid-RUN at head=7 while adv is high.
    #2 rst = 1'b1;
    #1;
    check_all("rst_mid_run", 0, 0, ST_IDLE, 1'b0);
    @(posedge clk); #1;
    check_all("rst_held", 0, 0, ST_IDLE, 1'b0);
    rst = 1'b0; run = 1'b1; dir = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst_entry", 0, 0, ST_RUN, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("post_rst_wait", i, 0, ST_RUN, 1'b0);
    end
    @(posedge clk); #1;
    check_all("post_rst_adv", 0, 1, ST_RUN, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/marquee_scheduler.md
# marquee_scheduler

Sequencing controller for the six-digit scrolling "GO BUFFS" marquee. It owns the scroll position (head index into the 10-symbol message) and produces the six character codes that feed the per-digit seven-segment decoders. Scrolling is paced by an internal prescaler and can run continuously, hold at the message start, or single-step manually. It replaces the free-running per-digit counters with one coherent, wrap-correct position.

## Interface
- MSG_LEN, 10: number of symbol codes in the message (codes 0..MSG_LEN-1); legal range 6..16.
- DIV, 25_000_000: clock cycles per scroll step; minimum 2.
- HOLD_STEPS, 3: scroll-step periods to dwell when head wraps to 0 during RUN; 0 disables hold.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = auto-scroll, 0 = idle.
- dir  in  1  0 = forward (head increments), 1 = backward (head decrements).
- step  in  1  single-cycle pulse; manual advance, honoured only in IDLE.
- head  out  4  current message position.
- ch0..ch5  out  4 each  symbol code for digit N (ch0 leftmost) = (head+N) mod MSG_LEN.
- adv  out  1  high for exactly the first cycle a new head is visible.
- state  out  2  00 IDLE, 01 RUN, 10 HOLD.

## Operation
- Reset values: head=0, ch0..ch5=0,1,2,3,4,5, adv=0, state=IDLE, prescaler=0, hold counter=0.
- Advance: forward head' = (head==MSG_LEN-1) ? 0 : head+1; backward head' = (head==0) ? MSG_LEN-1 : head-1. ch0..ch5 are registered and computed from head' on the same edge (single compare-subtract; head+N < 2*MSG_LEN). adv registered with head.
- IDLE: prescaler held at 0. step=1 -> one advance, remain IDLE. run=1 -> RUN, prescaler 0; step ignored that cycle.
- RUN: prescaler counts 0..DIV-1; at terminal count (DIV-1) the next edge advances and prescaler wraps to 0. If head'==0 (either direction) and HOLD_STEPS>0 -> HOLD with hold counter=HOLD_STEPS.
- HOLD: prescaler keeps counting; each terminal count decrements hold counter; terminal count with counter==1 -> RUN, no advance on that edge.
- run=0 in RUN or HOLD -> IDLE next edge, prescaler and hold counter cleared; has priority over a coincident terminal count (no advance).
- step outside IDLE: ignored, no effect.
- dir change: sampled at each advance edge; prescaler not disturbed.
- state=11 unreachable; if entered, return to IDLE next edge.

## Timing
- Manual step: step high at edge k -> head/ch/adv updated at edge k, adv high for cycle k..k+1 only.
- RUN entry at edge k -> first advance at edge k+DIV; subsequent advances every DIV cycles.
- Wrap to 0 in RUN at edge t -> HOLD for HOLD_STEPS*DIV cycles; RUN resumes at t+HOLD_STEPS*DIV; next advance at t+(HOLD_STEPS+1)*DIV.
- adv never high on two consecutive cycles (DIV>=2); never high in HOLD except the entry cycle.
- rst asserted mid-operation: all outputs to reset values immediately (async), independent of clk; first transition after deassertion evaluated at the next posedge.

## Test plan
- Reset/defaults (MSG_LEN=10, DIV=4, HOLD_STEPS=2): pulse rst mid-RUN with head=7 -> immediately head=0, ch=0,1,2,3,4,5, state=00, adv=0.
- Manual stepping: IDLE, dir=0, 10 step pulses 3 cycles apart -> head 1..9,0; after 4th step ch=4,5,6,7,8,9; after 5th ch=5,6,7,8,9,0; adv one cycle per step; step held during RUN -> no change.
- Auto-scroll cadence: run=1 from head=0 -> adv every 4 cycles, head 1,2,...,9; on wrap to 0 state=10 for 8 cycles, next advance (head=1) 12 cycles after wrap.
- Backward with wrap: dir=1, head=2, run=1 -> head 1, then 0 (enters HOLD), then 9 after hold; ch at head=9 = 9,0,1,2,3,4.
- Run drop priority: deassert run on the cycle prescaler==3 -> no advance, state=00 next edge; re-assert -> first advance exactly 4 cycles later.
- Direction flip mid-RUN: dir toggles between advances at head=5 -> next advance head=4, cadence unchanged (still 4 cycles).
